// File: rtl/lms_iq_interleaver.sv
// Serialises I/Q pairs onto one WIDTH-bit bus (I word, then Q word) framed by IQSEL.
// One-entry hold buffer; an empty hold at a stream-mode pair boundary fills (0,0) or the last pair.
module lms_iq_interleaver #(
  parameter int   WIDTH          = 12,
  parameter logic IQSEL_I_LEVEL  = 1'b1,
  parameter int   UNDERFLOW_HOLD = 0,
  parameter int   CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     const_i,
  input  logic [WIDTH-1:0]     const_q,
  input  logic [WIDTH-1:0]     in_i,
  input  logic [WIDTH-1:0]     in_q,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 iqsel_o,
  output logic [WIDTH-1:0]     data_o,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] underflow_count,
  input  logic                 clr_count
);

  logic                 r_p;
  logic                 r_hold_vld;
  logic [WIDTH-1:0]     r_hold_i;
  logic [WIDTH-1:0]     r_hold_q;
  logic [WIDTH-1:0]     r_last_i;
  logic [WIDTH-1:0]     r_last_q;
  logic [WIDTH-1:0]     r_ramp;
  logic [WIDTH-1:0]     r_act_q;
  logic [WIDTH-1:0]     r_data;
  logic                 r_iqsel;
  logic                 r_uf;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_bnd;
  logic                 w_stream;
  logic                 w_consume;
  logic                 w_uf;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_pair_i;
  logic [WIDTH-1:0]     w_pair_q;

  assign w_bnd     = ~r_p;
  assign w_stream  = (mode != 2'd1) && (mode != 2'd2);
  assign w_consume = w_bnd && enable && w_stream && r_hold_vld;
  assign w_uf      = w_bnd && enable && w_stream && !r_hold_vld;
  // Ready looks only at registered state and mode/enable, never at in_valid.
  assign in_ready  = rst_n && (!r_hold_vld || (w_bnd && enable && w_stream));
  assign w_accept  = in_valid && in_ready;

  assign iqsel_o         = r_iqsel;
  assign data_o          = r_data;
  assign underflow       = r_uf;
  assign underflow_count = r_cnt;

  always_comb begin
    w_pair_i = '0;
    w_pair_q = '0;
    if (enable) begin
      if (mode == 2'd1) begin
        w_pair_i = r_ramp;
        w_pair_q = ~r_ramp;
      end else if (mode == 2'd2) begin
        w_pair_i = const_i;
        w_pair_q = const_q;
      end else if (r_hold_vld) begin
        w_pair_i = r_hold_i;
        w_pair_q = r_hold_q;
      end else if (UNDERFLOW_HOLD != 0) begin
        w_pair_i = r_last_i;
        w_pair_q = r_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p        <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold_i   <= '0;
      r_hold_q   <= '0;
      r_last_i   <= '0;
      r_last_q   <= '0;
      r_ramp     <= '0;
      r_act_q    <= '0;
      r_data     <= '0;
      r_iqsel    <= ~IQSEL_I_LEVEL;
      r_uf       <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_p <= ~r_p;
      if (w_bnd) begin
        r_data  <= w_pair_i;
        r_act_q <= w_pair_q;
        r_iqsel <= IQSEL_I_LEVEL;
        r_uf    <= w_uf;
        if (enable) begin
          r_last_i <= w_pair_i;
          r_last_q <= w_pair_q;
        end
        if (enable && mode == 2'd1)
          r_ramp <= r_ramp + 1'b1;
      end else begin
        r_data  <= r_act_q;
        r_iqsel <= ~IQSEL_I_LEVEL;
        r_uf    <= 1'b0;
      end
      if (clr_count)
        r_cnt <= '0;
      else if (w_uf && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
      // Accept and consume in the same boundary cycle leaves the hold full.
      if (w_accept) begin
        r_hold_vld <= 1'b1;
        r_hold_i   <= in_i;
        r_hold_q   <= in_q;
      end else if (w_consume) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lms_iq_interleaver.md
Name: lms_iq_interleaver

Overview:
- Transmit end of the LMS6002D 12-bit multiplexed I/Q port.
- Takes I/Q sample pairs through a valid/ready handshake and serialises each pair onto one 12-bit bus: I word, then Q word, framed by an IQSEL line, one word per clock.
- Produces exactly the word stream that the board-level RX demux (IQSEL=1 -> I) consumes. Used for FPGA-internal loopback, BIST pattern generation, and as the bench driver for the RX demux.

Parameters:
- WIDTH, 12, sample word width (bus width).
- IQSEL_I_LEVEL, 1, IQSEL level that marks the I word.
- UNDERFLOW_HOLD, 0, underflow fill policy: 0 sends zeros, 1 repeats the last transmitted pair.
- CNT_WIDTH, 16, width of the underflow counter.

Ports:
- clk  in  1  LMS-rate word clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  run/mute control; sampled only at pair boundaries.
- mode  in  2  0 = stream from input, 1 = ramp pattern, 2 = constant, 3 = reserved (behaves as 0).
- const_i  in  WIDTH  I value for mode 2.
- const_q  in  WIDTH  Q value for mode 2.
- in_i  in  WIDTH  input I sample.
- in_q  in  WIDTH  input Q sample.
- in_valid  in  1  input pair valid.
- in_ready  out  1  pair accepted when in_valid && in_ready.
- iqsel_o  out  1  registered framing output.
- data_o  out  WIDTH  registered interleaved data.
- underflow  out  1  one-cycle pulse per underflowed pair.
- underflow_count  out  CNT_WIDTH  saturating count of underflowed pairs.
- clr_count  in  1  synchronous clear of underflow_count.

Behaviour:
- Reset (rst_n=0 at a rising edge): data_o=0, iqsel_o=~IQSEL_I_LEVEL, in_ready=0, underflow=0, underflow_count=0, hold buffer empty, last pair=0, ramp counter=0, phase p=0.
- Phase p toggles every cycle from the first cycle after reset release, regardless of enable or mode.
- iqsel_o is registered: iqsel_o <= (p==0) ? IQSEL_I_LEVEL : ~IQSEL_I_LEVEL. IQSEL never stalls.
- Pair boundary = cycle with p=0. At the boundary the active pair (a_i, a_q) is loaded and data_o <= I word. At p=1, data_o <= a_q.
- Active pair source at the boundary:
  - enable=0: (0,0); no underflow; hold buffer is not consumed.
  - mode 1: (ramp, ~ramp); ramp increments by 1 per pair and wraps 0xFFF -> 0x000.
  - mode 2: (const_i, const_q), sampled at the boundary.
  - mode 0/3 with hold full: hold contents; hold empties in the same cycle.
  - mode 0/3 with hold empty: underflow. Pair is (0,0), or the last pair if UNDERFLOW_HOLD=1. underflow pulses in that cycle; underflow_count increments and saturates at all-ones.
- Hold buffer: one entry.
  - in_ready = rst_n && (hold empty || (p==0 && enable && mode stream)).
  - in_ready is combinational from registered state only; it has no path from in_valid.
  - Simultaneous accept and consume at a boundary is legal and sustains full rate (one pair per 2 clocks).
  - In modes 1/2 the hold buffer retains its content and is not overwritten.
- Latency: a pair accepted into an empty hold at cycle t, where t+1 is a boundary, shows its I word on data_o after the t+1 edge and its Q word one cycle later. Data is never reordered or split across pairs.
- "Last pair" register updates on every boundary load except when enable=0.
- clr_count has priority over a same-cycle increment; the count becomes 0.
- Reset mid-pair: Q word is dropped, outputs return to reset values next cycle, hold buffer is discarded.

Test Plan:
- Reset, then enable=1, mode 0, in_valid=1 streaming pairs (0x123,0xABC), (0x456,0xDEF) -> data_o sequence 0x123,0xABC,0x456,0xDEF with iqsel_o 1,0,1,0; underflow never pulses; in_ready sustains one accept per 2 clocks.
- mode 0, in_valid=0 for 3 boundaries, UNDERFLOW_HOLD=0 -> data_o all zero, 3 underflow pulses, underflow_count=3. Repeat with UNDERFLOW_HOLD=1 after pair (0x7FF,0x800) -> 0x7FF/0x800 repeated.
- mode 1 from reset -> pairs (0x000,0xFFF), (0x001,0xFFE), ...; after 4096 pairs the ramp wraps to (0x000,0xFFF).
- mode 2, const_i=0x5A5, const_q=0xA5A, const changed mid-pair -> change applies only at the next boundary; Q word never mixes old and new values.
- enable deasserted during a Q word -> that Q word completes, next pair is (0,0), iqsel keeps toggling, count unchanged; force count to 0xFFFF with further underflows -> stays 0xFFFF; clr_count concurrent with an underflow -> 0.
- rst_n low during a Q word with hold full -> next cycle data_o=0, iqsel_o=0, in_ready=0; after release, the first I word is an underflow (hold discarded).
